fifo_drain_unit: RTL

FIFO_DRAIN_UNIT -- requirements
Module: fifo_drain_unit

---
 rtl/fifo_drain_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_drain_unit.sv
// fifo_drain_unit: pops up to a programmed number of entries from an upstream
// FIFO into a one-entry output register, tracking count and XOR checksum.
module fifo_drain_unit #(
    parameter int ENTRY_WIDTH = 32,
    parameter int N_ENTRIES   = 8,
    localparam int CTR_WIDTH  = $clog2(N_ENTRIES) + 1
) (
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic                   start,
    input  logic [CTR_WIDTH-1:0]   max_count,
    input  logic                   deq_valid,
    input  logic [ENTRY_WIDTH-1:0] deq_data,
    output logic                   deq_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ENTRY_WIDTH-1:0] out_data,
    output logic [CTR_WIDTH-1:0]   drained_count,
    output logic [ENTRY_WIDTH-1:0] checksum,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t               state_q, state_d;
    logic                 done_d;
    logic [CTR_WIDTH-1:0] max_q;
    logic                 start_go;
    logic                 pop;
    logic                 below_limit;
    logic                 limit_hit;

    assign start_go    = (state_q == IDLE) && start;
    assign below_limit = drained_count < max_q;
    // Output slot is free when empty or being consumed this cycle.
    assign deq_ready   = (state_q == DRAIN) && (!out_valid || out_ready) && below_limit;
    assign pop         = deq_valid && deq_ready;
    assign limit_hit   = pop && ((drained_count + CTR_WIDTH'(1)) == max_q);
    assign busy        = (state_q != IDLE);

    // Next-state and done-pulse decode.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (max_count != '0) state_d = DRAIN;
                    else                 done_d  = 1'b1;
                end
            end
            DRAIN: begin
                // Limit exit is checked first so it wins over the empty exit.
                if (limit_hit)                    state_d = FLUSH;
                else if (deq_ready && !deq_valid) state_d = FLUSH;
            end
            FLUSH: begin
                if (!out_valid || out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and registered done pulse.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q <= IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    // Drain bookkeeping: latched limit, count and checksum.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            max_q         <= '0;
            drained_count <= '0;
            checksum      <= '0;
        end else if (start_go) begin
            drained_count <= '0;
            checksum      <= '0;
            if (max_count != '0) max_q <= max_count;
        end else if (pop) begin
            drained_count <= drained_count + CTR_WIDTH'(1);
            checksum      <= checksum ^ deq_data;
        end
    end

    // Output register: load on pop, drop once consumed, hold while stalled.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= deq_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
